// File: rtl/item_eat_detector.sv
// Watches Pac-Man's tile, issues one registered eat event per newly entered item tile,
// keeps the saturating score, stalls Pac-Man after eating and flags level clear.
module item_eat_detector #(
  parameter int unsigned P_DOT_POINTS       = 10,
  parameter int unsigned P_ENERGIZER_POINTS = 50,
  parameter int unsigned P_DOT_STALL        = 1,
  parameter int unsigned P_ENERGIZER_STALL  = 3,
  parameter int unsigned P_SCORE_MAX        = 999990
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_frame_tick,
  input  logic        i_pac_valid,
  input  logic [5:0]  i_pac_x,
  input  logic [5:0]  i_pac_y,
  input  logic [1:0]  i_items [0:35][0:27],
  input  logic        i_items_reload,
  input  logic        i_reload_done,
  input  logic [7:0]  i_dots_counter,
  input  logic [3:0]  i_energizer_counter,
  input  logic        i_score_clear,
  output logic        o_item_eaten,
  output logic [1:0]  o_item_eaten_type,
  output logic [5:0]  o_item_x,
  output logic [5:0]  o_item_y,
  output logic        o_energizer_trigger,
  output logic        o_pac_stall,
  output logic [19:0] o_score,
  output logic        o_level_clear
);

  typedef enum logic [2:0] {S_RELOAD, S_IDLE, S_EMIT, S_WAIT, S_STALL} state_t;

  localparam logic [20:0] DOT_PTS   = 21'(P_DOT_POINTS);
  localparam logic [20:0] EN_PTS    = 21'(P_ENERGIZER_POINTS);
  localparam logic [20:0] SCORE_MAX = 21'(P_SCORE_MAX);
  localparam logic [7:0]  DOT_STALL = 8'(P_DOT_STALL);
  localparam logic [7:0]  EN_STALL  = 8'(P_ENERGIZER_STALL);

  state_t      state;
  logic [5:0]  last_x;
  logic [5:0]  last_y;
  logic        last_valid;
  logic [7:0]  stall_cnt;
  logic [1:0]  tile_item;
  logic        tile_new;
  logic        tile_has_item;
  logic        detect;
  logic [20:0] score_sum;

  // Off-map coordinates read as an empty tile; y <= 27 guarantees bit 5 is zero.
  always_comb begin
    tile_item = 2'd0;
    if (i_pac_x <= 6'd35 && i_pac_y <= 6'd27)
      tile_item = i_items[i_pac_x][i_pac_y[4:0]];
  end

  assign tile_has_item = (tile_item == 2'd1) || (tile_item == 2'd2);
  assign tile_new      = !last_valid || (i_pac_x != last_x) || (i_pac_y != last_y);
  assign detect        = (state == S_IDLE) && !i_items_reload && i_pac_valid
                         && tile_new && tile_has_item;
  assign score_sum     = {1'b0, o_score} + ((tile_item == 2'd2) ? EN_PTS : DOT_PTS);

  // Score is added on the detection edge so it appears together with the eat pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      o_score <= 20'd0;
    else if (i_score_clear)
      o_score <= 20'd0;
    else if (detect)
      o_score <= (score_sum > SCORE_MAX) ? SCORE_MAX[19:0] : score_sum[19:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state               <= S_RELOAD;
      last_x              <= 6'd0;
      last_y              <= 6'd0;
      last_valid          <= 1'b0;
      stall_cnt           <= 8'd0;
      o_item_eaten        <= 1'b0;
      o_item_eaten_type   <= 2'd0;
      o_item_x            <= 6'd0;
      o_item_y            <= 6'd0;
      o_energizer_trigger <= 1'b0;
      o_pac_stall         <= 1'b0;
      o_level_clear       <= 1'b0;
    end else begin
      o_item_eaten        <= 1'b0;
      o_energizer_trigger <= 1'b0;
      if (i_items_reload) begin
        state         <= S_RELOAD;
        last_valid    <= 1'b0;
        stall_cnt     <= 8'd0;
        o_pac_stall   <= 1'b0;
        o_level_clear <= 1'b0;
      end else begin
        if (state == S_IDLE && i_dots_counter == 8'd0 && i_energizer_counter == 4'd4)
          o_level_clear <= 1'b1;
        case (state)
          S_RELOAD: if (i_reload_done) state <= S_IDLE;
          S_IDLE: begin
            if (!i_pac_valid) begin
              last_valid <= 1'b0;
            end else if (tile_new) begin
              last_x     <= i_pac_x;
              last_y     <= i_pac_y;
              last_valid <= 1'b1;
              if (tile_has_item) begin
                o_item_eaten        <= 1'b1;
                o_item_eaten_type   <= tile_item;
                o_item_x            <= i_pac_x;
                o_item_y            <= i_pac_y;
                o_energizer_trigger <= (tile_item == 2'd2);
                o_pac_stall         <= 1'b1;
                state               <= S_EMIT;
              end
            end
          end
          S_EMIT: state <= S_WAIT;
          S_WAIT: begin
            stall_cnt <= (o_item_eaten_type == 2'd2) ? EN_STALL : DOT_STALL;
            state     <= S_STALL;
          end
          S_STALL: begin
            // A zero-length stall parameter still releases on the first tick.
            if (i_frame_tick) begin
              if (stall_cnt <= 8'd1) begin
                state       <= S_IDLE;
                o_pac_stall <= 1'b0;
              end else begin
                stall_cnt <= stall_cnt - 8'd1;
              end
            end
          end
          default: state <= S_RELOAD;
        endcase
      end
    end
  end

endmodule
